seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 WIDTH, 16, datapath width; SHALL be a power of two >= 4.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset:
  clk  input  1  rising-edge clock.
  reset  input  1  asynchronous active-high reset.
REQ-003 in_valid  input  1  operation request.
REQ-004 in_ready  output  1  block can accept an operation.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B; low log2(WIDTH) bits are the shift amount for shifts.
REQ-007 control  input  4  opcode.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 y  output  WIDTH  registered result.
REQ-011 flags  output  4  registered {overflow, negative, carry, zero}.

Function
REQ-012 Opcodes SHALL be: 0 add, 1 sub (a-b), 2 xor, 3 and, 4 inc a, 5 dec a, 6 shl, 7 shr logical, 8 sar, 9 or; all others undefined.
REQ-013 FSM states SHALL be IDLE, BUSY and DONE; in_ready = (state==IDLE) and not reset.
REQ-014 Accept SHALL occur on a rising edge with in_valid && in_ready; a, b and control are latched then, and later input changes SHALL have no effect.
REQ-015 Latency L (accept edge N to out_valid high after edge N+L) SHALL be 1 for opcodes 0-5, 9 and undefined opcodes; 1+shamt for shifts, with shamt = b mod WIDTH.
REQ-016 Shifts SHALL move one bit per cycle in BUSY; shamt 0 goes IDLE->DONE with y = a.
REQ-017 In DONE, out_valid=1 and y/flags SHALL hold stable until out_valid && out_ready, then the FSM returns to IDLE on that edge.
REQ-018 No new operation SHALL be accepted in the completing cycle; peak throughput is one op per L+1 cycles.
REQ-019 Arithmetic SHALL be modulo 2^WIDTH.
REQ-020 zero = (y==0); negative = y[WIDTH-1].
REQ-021 carry SHALL be: carry-out for add/inc; borrow (a<b unsigned, or a==0 for dec) for sub/dec; last bit shifted out for shifts (0 if shamt 0); 0 otherwise.
REQ-022 overflow SHALL be signed overflow for add/sub/inc/dec and 0 otherwise.
REQ-023 Undefined opcodes SHALL give y=0, flags=4'b0001.

Reset
REQ-024 On reset: state IDLE, out_valid 0, y 0, flags 0; in_ready SHALL be 0 while reset is asserted.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the operation; no result is ever presented for it.
REQ-026 First accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro ALU_MUL_EN, when defined, SHALL add opcode 10 (unsigned product, low WIDTH bits) and opcode 11 (high WIDTH bits), computed shift-add in BUSY with L = WIDTH+1.
REQ-028 With ALU_MUL_EN defined, opcode 10 carry SHALL = (high half != 0); opcode 11 carry = 0; overflow = 0 for both.
REQ-029 Without ALU_MUL_EN, opcodes 10 and 11 SHALL behave as undefined (REQ-023, L=1) and no multiplier logic SHALL be present.

Verification (WIDTH=16)
REQ-030 add a=0xFFFF b=0x0001 -> y=0x0000, flags=0b0011, out_valid one cycle after accept.
REQ-031 sub a=0x8000 b=0x0001 -> y=0x7FFF, overflow=1, carry=0, negative=0.
REQ-032 sar a=0x8004 b=0x0003 -> y=0xF000, carry=1, negative=1, L=4; shl b=0x0010 (shamt 0) -> y=a, L=1.
REQ-033 out_ready held low 5 cycles in DONE with in_valid high -> y/flags stable, in_ready=0, no extra accept; single handshake on out_ready.
REQ-034 reset pulsed 3 cycles into shr b=15 -> out_valid stays 0, y=0, next op accepted normally after deassert.
REQ-035 ALU_MUL_EN: op10 0x0100*0x0100 -> y=0, carry=1, zero=1, L=17; op11 -> y=0x0001; without macro op10 -> y=0, flags=0b0001, L=1.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential handshaked ALU: single-cycle logic/arith ops, bit-serial shifts.
// Define ALU_MUL_EN to add a shift-add multiplier (opcode 10 low half, 11 high half).
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_INC   = 4'd4;
    localparam logic [3:0] OP_DEC   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_SAR   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MULLO = 4'd10;
    localparam logic [3:0] OP_MULHI = 4'd11;
`endif

    logic [1:0]       state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] work;
    logic [SW:0]      count;
    logic [SW-1:0]    shamt;
    logic             is_shift;
    logic             is_mul;
    logic             start_busy;
    logic [WIDTH-1:0] comb_y;
    logic             comb_c;
    logic             comb_v;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] step_work;
    logic             step_bit;
    logic [WIDTH-1:0] busy_y;
    logic             busy_c;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] step_prod;
    logic [WIDTH:0]     mul_sum;
`endif

    assign in_ready = (state == IDLE) && !reset;
    assign shamt    = b[SW-1:0];
    assign is_shift = (control == OP_SHL) || (control == OP_SHR) || (control == OP_SAR);
`ifdef ALU_MUL_EN
    assign is_mul   = (control == OP_MULLO) || (control == OP_MULHI);
`else
    assign is_mul   = 1'b0;
`endif
    assign start_busy = (is_shift && (shamt != '0)) || is_mul;

    // Results that complete straight from IDLE; a zero-distance shift passes a through.
    always_comb begin
        comb_y = '0;
        comb_c = 1'b0;
        comb_v = 1'b0;
        wide   = '0;
        case (control)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                comb_y = wide[WIDTH-1:0];
                comb_c = wide[WIDTH];
                comb_v = (a[WIDTH-1] == b[WIDTH-1]) && (comb_y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                comb_y = wide[WIDTH-1:0];
                comb_c = wide[WIDTH];
                comb_v = (a[WIDTH-1] != b[WIDTH-1]) && (comb_y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR: comb_y = a ^ b;
            OP_AND: comb_y = a & b;
            OP_OR:  comb_y = a | b;
            OP_INC: begin
                wide   = {1'b0, a} + (WIDTH+1)'(1);
                comb_y = wide[WIDTH-1:0];
                comb_c = wide[WIDTH];
                comb_v = !a[WIDTH-1] && comb_y[WIDTH-1];
            end
            OP_DEC: begin
                wide   = {1'b0, a} - (WIDTH+1)'(1);
                comb_y = wide[WIDTH-1:0];
                comb_c = wide[WIDTH];
                comb_v = a[WIDTH-1] && !comb_y[WIDTH-1];
            end
            OP_SHL, OP_SHR, OP_SAR: comb_y = a;
            default: ;
        endcase
    end

    // One iteration of the multi-cycle datapath; busy_y/busy_c is what lands on the last step.
    always_comb begin
        step_work = work;
        step_bit  = 1'b0;
        case (op_q)
            OP_SHL: begin
                step_work = {work[WIDTH-2:0], 1'b0};
                step_bit  = work[WIDTH-1];
            end
            OP_SHR: begin
                step_work = {1'b0, work[WIDTH-1:1]};
                step_bit  = work[0];
            end
            OP_SAR: begin
                step_work = {work[WIDTH-1], work[WIDTH-1:1]};
                step_bit  = work[0];
            end
            default: ;
        endcase
        busy_y = step_work;
        busy_c = step_bit;
`ifdef ALU_MUL_EN
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, work} : '0);
        step_prod = {mul_sum, prod[WIDTH-1:1]};
        if (op_q == OP_MULLO) begin
            busy_y = step_prod[WIDTH-1:0];
            busy_c = |step_prod[2*WIDTH-1:WIDTH];
        end else if (op_q == OP_MULHI) begin
            busy_y = step_prod[2*WIDTH-1:WIDTH];
            busy_c = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= '0;
            work      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            flags     <= '0;
`ifdef ALU_MUL_EN
            prod      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= control;
                        work <= a;
                        if (start_busy) begin
                            state <= BUSY;
                            count <= is_mul ? (SW+1)'(WIDTH) : {1'b0, shamt};
`ifdef ALU_MUL_EN
                            prod  <= {{WIDTH{1'b0}}, b};
`endif
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            y         <= comb_y;
                            flags     <= {comb_v, comb_y[WIDTH-1], comb_c, comb_y == '0};
                        end
                    end
                end
                BUSY: begin
                    work  <= step_work;
                    count <= count - 1'b1;
`ifdef ALU_MUL_EN
                    prod  <= step_prod;
`endif
                    if (count == (SW+1)'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        y         <= busy_y;
                        flags     <= {1'b0, busy_y[WIDTH-1], busy_c, busy_y == '0};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes model results, monitor pops on each presented result.
module tb_seq_alu;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [3:0]   flags;

    typedef struct {
        logic [15:0] y;
        logic [3:0]  f;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   force_stall = 1'b0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .control(control), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Reference model from the opcode rules using plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv);
        exp_t   e;
        int     ua, ub, sa, sb, r, s;
        longint p;
        bit     c, v;
        ua = int'(av);
        ub = int'(bv);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        s  = ub % 16;
        p  = longint'(ua) * longint'(ub);
        r = 0; c = 0; v = 0; e.lat = 1; e.acc = 0;
        case (op)
            4'd0: begin r = ua + ub; c = r > 65535; v = (sa + sb > 32767) || (sa + sb < -32768); end
            4'd1: begin r = ua - ub; c = ua < ub; v = (sa - sb > 32767) || (sa - sb < -32768); end
            4'd2: r = ua ^ ub;
            4'd3: r = ua & ub;
            4'd4: begin r = ua + 1; c = r > 65535; v = sa + 1 > 32767; end
            4'd5: begin r = ua - 1; c = ua == 0; v = sa - 1 < -32768; end
            4'd6: begin r = ua << s; c = (s != 0) && (((ua >> (16 - s)) & 1) != 0); e.lat = 1 + s; end
            4'd7: begin r = ua >> s; c = (s != 0) && (((ua >> (s - 1)) & 1) != 0); e.lat = 1 + s; end
            4'd8: begin r = sa >>> s; c = (s != 0) && (((ua >> (s - 1)) & 1) != 0); e.lat = 1 + s; end
            4'd9: r = ua | ub;
`ifdef ALU_MUL_EN
            4'd10: begin r = int'(p & 64'hFFFF); c = (p >> 16) != 0; e.lat = 17; end
            4'd11: begin r = int'((p >> 16) & 64'hFFFF); e.lat = 17; end
`endif
            default: r = 0;
        endcase
        e.y = r[15:0];
        e.f = {v, e.y[15], c, e.y == 16'h0000};
        return e;
    endfunction

    // Waits for in_ready with inputs already driven; records the expectation if asked.
    task automatic wait_accept(input bit push);
        int   budget = 200;
        exp_t e;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e = model(control, a, b);
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        control  = 4'($urandom);
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv, input bit push);
        @(negedge clk);
        control  = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        wait_accept(push);
    endtask

    task automatic wait_idle();
        int budget = 500;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compares each presented result, holds out_ready low on request.
    initial begin : monitor
        bit   seen = 1'b0;
        bit   expect_low = 1'b0;
        int   stall_left = 0;
        exp_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen       = 1'b0;
                expect_low = 1'b0;
                out_ready  = 1'b0;
            end else begin
                if (expect_low) begin
                    check_output("valid_drop_after_handshake", 32'(out_valid), 32'd0);
                    expect_low = 1'b0;
                end
                if (out_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_result: y=0x%0h flags=0x%0h with no operation outstanding", y, flags);
                            e.y = y;
                            e.f = flags;
                        end else begin
                            e = exp_q[0];
                            check_output("result_y", 32'(y), 32'(e.y));
                            check_output("result_flags", 32'(flags), 32'(e.f));
                            check_output("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                        end
                        stall_left  = force_stall ? 5 : 0;
                        force_stall = 1'b0;
                    end else begin
                        check_output("held_y", 32'(y), 32'(e.y));
                        check_output("held_flags", 32'(flags), 32'(e.f));
                    end
                    check_output("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (out_ready) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        seen       = 1'b0;
                        expect_low = 1'b1;
                    end
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin : driver
        reset    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        control  = '0;
        @(negedge clk);
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_y", 32'(y), 32'd0);
        check_output("reset_flags", 32'(flags), 32'd0);
        check_output("reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("in_ready_after_reset", 32'(in_ready), 32'd1);

        apply_stimulus(4'd0, 16'hFFFF, 16'h0001, 1'b1);
        apply_stimulus(4'd1, 16'h8000, 16'h0001, 1'b1);
        apply_stimulus(4'd8, 16'h8004, 16'h0003, 1'b1);
        apply_stimulus(4'd6, 16'h1234, 16'h0010, 1'b1);
        apply_stimulus(4'd4, 16'hFFFF, 16'h0000, 1'b1);
        apply_stimulus(4'd4, 16'h7FFF, 16'h0000, 1'b1);
        apply_stimulus(4'd5, 16'h0000, 16'h0000, 1'b1);
        apply_stimulus(4'd5, 16'h8000, 16'h0000, 1'b1);
        apply_stimulus(4'd6, 16'h0001, 16'h000F, 1'b1);
        apply_stimulus(4'd8, 16'h8000, 16'h000F, 1'b1);
        apply_stimulus(4'd7, 16'h0003, 16'h0001, 1'b1);
        apply_stimulus(4'd10, 16'h0100, 16'h0100, 1'b1);
        apply_stimulus(4'd11, 16'h0100, 16'h0100, 1'b1);
        apply_stimulus(4'd15, 16'hABCD, 16'h1234, 1'b1);

        // Long stall in DONE while the next request is already waiting.
        wait_idle();
        force_stall = 1'b1;
        apply_stimulus(4'd9, 16'hA5A5, 16'h0F0F, 1'b1);
        apply_stimulus(4'd2, 16'hFFFF, 16'h00FF, 1'b1);

        // Reset in the middle of a long shift; only the following op may produce a result.
        wait_idle();
        apply_stimulus(4'd7, 16'($urandom), 16'h000F, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        control  = 4'd3;
        a        = 16'hF0F0;
        b        = 16'h3C3C;
        in_valid = 1'b1;
        #1;
        check_output("abort_out_valid", 32'(out_valid), 32'd0);
        check_output("abort_y", 32'(y), 32'd0);
        check_output("abort_flags", 32'(flags), 32'd0);
        check_output("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("in_ready_after_abort", 32'(in_ready), 32'd1);
        wait_accept(1'b1);

        repeat (300) apply_stimulus(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'b1);

        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
